status_checkpoint: RTL and testbench
====================================

STATUS_CHECKPOINT -- requirements
Module: status_checkpoint

Interface
REQ-001 Parameter: REG, 4, register index MSB (32 architectural registers).
REQ-002 Parameter: WIDTH, 31, busy-vector MSB.
REQ-003 Parameter: CKPT, 1, checkpoint tag MSB (4 checkpoints).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low; asserted (0) clears state immediately.
REQ-006 snapValid  in  1  branch in rename stage; capture regStatusSnap this cycle.
REQ-007 regStatusSnap  in  WIDTH+1  current busy vector from the register status file.
REQ-008 commitValid  in  1  an instruction writing a destination register commits this cycle.
REQ-009 regCommit  in  REG+1  destination register of the committing instruction.
REQ-010 branchCommit  in  1  oldest branch retires; frees the oldest checkpoint.
REQ-011 mispredict  in  1  branch identified by misTag resolved mispredicted.
REQ-012 misTag  in  CKPT+1  checkpoint tag of the mispredicted branch.
REQ-013 snapTag  out  CKPT+1  tag assigned to a capture this cycle (combinational, equals tail).
REQ-014 full  out  1  all 4 checkpoints occupied (combinational).
REQ-015 restore  out  1  one-cycle pulse driving the register status file's restore/reset input.
REQ-016 statusRestore  out  WIDTH+1  busy vector to reload; valid while restore=1.

Function
REQ-017 Storage SHALL be a circular buffer of 4 entries x 32 bits with head (oldest), tail (next free), and count (0..4) registers.
REQ-018 full SHALL equal (count==4); snapTag SHALL equal tail.
REQ-019 Capture: snapValid & !full & !mispredict SHALL write entry[tail], then tail+1 (wrap 3->0) and count+1.
REQ-020 The captured value SHALL be regStatusSnap with bit regCommit cleared when commitValid is high in the same cycle.
REQ-021 snapValid while full SHALL be ignored, with no state change; upstream stalls on full.
REQ-022 Commit scrub: when commitValid is high, bit regCommit SHALL be cleared in every occupied entry on that edge.
REQ-023 branchCommit with count>0 SHALL advance head (wrap) and decrement count; branchCommit with count==0 SHALL be ignored.
REQ-024 Mispredict with misTag occupied SHALL, on the next edge, set tail=misTag+1 and count=((misTag-head) mod 4)+1, retaining misTag's own entry and squashing all younger entries.
REQ-025 On that same edge, restore SHALL be 1 and statusRestore SHALL equal entry[misTag] after the same-cycle commit scrub.
REQ-026 restore SHALL return to 0 the following cycle unless another mispredict occurs; statusRestore SHALL hold its last value.
REQ-027 A mispredict whose misTag is not occupied SHALL be ignored, with restore staying 0.
REQ-028 Mispredict SHALL take priority over a same-cycle snapValid; the capture is dropped.
REQ-029 Mispredict with a same-cycle branchCommit SHALL apply both: head+1 and count=((misTag-head) mod 4); when misTag==head the result is count 0 with tail=head+1.
REQ-030 Capture with a same-cycle branchCommit at count==4 SHALL NOT capture (full is evaluated before the update).
REQ-031 Count arithmetic SHALL be 3-bit unsigned; pointer arithmetic SHALL be CKPT+1-bit modulo 4.

Reset
REQ-032 While reset==0: head=0, tail=0, count=0, restore=0, statusRestore=0; entry contents are don't-care (no entry is occupied).
REQ-033 Reset asserted mid-restore SHALL force restore=0 immediately.

Verification
REQ-034 Capture 0x0000_00F0 with commitValid=1, regCommit=5 -> snapTag=0, count=1, entry0=0x0000_00D0.
REQ-035 Four captures, then a fifth snapValid -> full=1, fifth capture ignored, tail=0, count=4.
REQ-036 Tags 0,1,2 occupied, mispredict misTag=1 -> next cycle restore=1, statusRestore=entry1, tail=2, count=2; one cycle later restore=0.
REQ-037 Entry0=0xFFFF_FFFE, commitValid on regCommit=3 then 7, then mispredict misTag=0 -> statusRestore=0xFFFF_FF76.
REQ-038 head=3 wrap case: occupy tags 3,0, mispredict misTag=0 with branchCommit same cycle -> head=0, tail=1, count=1, restore=1.
REQ-039 Assert reset (0) during a restore pulse -> restore=0, count=0, full=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/status_checkpoint_if.sv
// Rename-stage checkpoint bus: busy-vector capture, commit scrub, branch
// retire/mispredict in one direction; checkpoint tag/occupancy/restore back.
interface status_checkpoint_if #(
  parameter int REG   = 4,
  parameter int WIDTH = 31,
  parameter int CKPT  = 1
);
  logic             snapValid;
  logic [WIDTH:0]   regStatusSnap;
  logic             commitValid;
  logic [REG:0]     regCommit;
  logic             branchCommit;
  logic             mispredict;
  logic [CKPT:0]    misTag;
  logic [CKPT:0]    snapTag;
  logic             full;
  logic             restore;
  logic [WIDTH:0]   statusRestore;

  modport master (
    output snapValid, regStatusSnap, commitValid, regCommit,
           branchCommit, mispredict, misTag,
    input  snapTag, full, restore, statusRestore
  );

  modport slave (
    input  snapValid, regStatusSnap, commitValid, regCommit,
           branchCommit, mispredict, misTag,
    output snapTag, full, restore, statusRestore
  );
endinterface

// File: rtl/status_checkpoint.sv
// Circular buffer of register busy-vector checkpoints taken at branches;
// a mispredict restores the branch's (commit-scrubbed) snapshot and squashes younger ones.
module status_checkpoint #(
  parameter int REG   = 4,
  parameter int WIDTH = 31,
  parameter int CKPT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  status_checkpoint_if.slave ckpt
);
  localparam int PW    = CKPT + 1;
  localparam int DEPTH = 1 << PW;
  localparam int CNTW  = CKPT + 2;

  logic [WIDTH:0]  entry   [DEPTH];
  logic [WIDTH:0]  entry_n [DEPTH];
  logic [CKPT:0]   head, head_n;
  logic [CKPT:0]   tail, tail_n;
  logic [CNTW-1:0] count, count_n;
  logic            restore_q, restore_n;
  logic [WIDTH:0]  status_q, status_n;

  logic [REG:0]    commit_idx;
  logic [WIDTH:0]  scrub_mask;
  logic [WIDTH:0]  snap_scrubbed;
  logic [DEPTH-1:0] occ;
  logic            is_full;
  logic            mis_ok;
  logic            cap;
  logic            bc;
  logic [CKPT:0]   mis_off;

  // A tag is live when its distance from head is below the occupancy count.
  function automatic logic is_occ(input logic [CKPT:0] tag,
                                  input logic [CKPT:0] hd,
                                  input logic [CNTW-1:0] cnt);
    logic [CKPT:0] off;
    off = tag - hd;
    return {1'b0, off} < cnt;
  endfunction

  assign commit_idx = ckpt.regCommit;
  assign is_full    = (count == CNTW'(DEPTH));

  assign ckpt.full          = is_full;
  assign ckpt.snapTag       = tail;
  assign ckpt.restore       = restore_q;
  assign ckpt.statusRestore = status_q;

  always_comb begin
    scrub_mask = '1;
    if (ckpt.commitValid) scrub_mask[commit_idx] = 1'b0;
    snap_scrubbed = ckpt.regStatusSnap & scrub_mask;
  end

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ[i] = is_occ(PW'(i), head, count);
    end
  end

  // Control: mispredict outranks capture; branch retire applies in either case.
  always_comb begin
    mis_ok    = ckpt.mispredict && is_occ(ckpt.misTag, head, count);
    cap       = ckpt.snapValid && !is_full && !ckpt.mispredict;
    bc        = ckpt.branchCommit && (count != '0);
    mis_off   = ckpt.misTag - head;
    head_n    = head + PW'(bc);
    tail_n    = tail;
    count_n   = count;
    restore_n = 1'b0;
    status_n  = status_q;

    if (mis_ok) begin
      tail_n    = ckpt.misTag + PW'(1);
      count_n   = {1'b0, mis_off} + CNTW'(1) - CNTW'(bc);
      restore_n = 1'b1;
      status_n  = entry[ckpt.misTag] & scrub_mask;
    end else begin
      tail_n  = tail + PW'(cap);
      count_n = count + CNTW'(cap) - CNTW'(bc);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_n[i] = entry[i];
      if (occ[i]) entry_n[i] = entry[i] & scrub_mask;
    end
    if (cap) entry_n[tail] = snap_scrubbed;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      restore_q <= 1'b0;
      status_q  <= '0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      restore_q <= restore_n;
      status_q  <= status_n;
    end
  end

  // Entry payload needs no reset: nothing is occupied after reset.
  always_ff @(posedge clk) begin
    entry <= entry_n;
  end
endmodule

// File: tb/tb_status_checkpoint.sv
// Directed bench for status_checkpoint with hand-computed expectations.
module tb_status_checkpoint;
  localparam int REG   = 4;
  localparam int WIDTH = 31;
  localparam int CKPT  = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  status_checkpoint_if #(.REG(REG), .WIDTH(WIDTH), .CKPT(CKPT)) ckpt ();

  status_checkpoint #(.REG(REG), .WIDTH(WIDTH), .CKPT(CKPT)) dut (
    .clk   (clk),
    .reset (reset),
    .ckpt  (ckpt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ckpt.snapValid     = 1'b0;
    ckpt.regStatusSnap = '0;
    ckpt.commitValid   = 1'b0;
    ckpt.regCommit     = '0;
    ckpt.branchCommit  = 1'b0;
    ckpt.mispredict    = 1'b0;
    ckpt.misTag        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic capture(input logic [31:0] v);
    ckpt.snapValid     = 1'b1;
    ckpt.regStatusSnap = v;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check("rst_restore", 32'(ckpt.restore), 32'd0);
    check("rst_status",  ckpt.statusRestore, 32'h0);
    check("rst_full",    32'(ckpt.full), 32'd0);
    check("rst_tag",     32'(ckpt.snapTag), 32'd0);
    check("rst_count",   32'(dut.count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // capture with same-cycle commit on bit 5
    check("cap0_tag_pre", 32'(ckpt.snapTag), 32'd0);
    ckpt.commitValid = 1'b1;
    ckpt.regCommit   = 5'd5;
    capture(32'h0000_00F0);
    check("cap0_count", 32'(dut.count), 32'd1);
    check("cap0_entry", dut.entry[0], 32'h0000_00D0);
    check("cap0_tag",   32'(ckpt.snapTag), 32'd1);

    capture(32'h11);
    capture(32'h22);
    capture(32'h33);
    check("fill_full",  32'(ckpt.full), 32'd1);
    check("fill_tag",   32'(ckpt.snapTag), 32'd0);
    check("fill_count", 32'(dut.count), 32'd4);

    capture(32'h44);
    check("ovf_count", 32'(dut.count), 32'd4);
    check("ovf_tag",   32'(ckpt.snapTag), 32'd0);
    check("ovf_entry", dut.entry[0], 32'h0000_00D0);

    // capture blocked at full even when a branch retires the same cycle
    ckpt.branchCommit = 1'b1;
    capture(32'h55);
    check("bcfull_count", 32'(dut.count), 32'd3);
    check("bcfull_head",  32'(dut.head), 32'd1);
    check("bcfull_tag",   32'(ckpt.snapTag), 32'd0);
    check("bcfull_full",  32'(ckpt.full), 32'd0);
    check("bcfull_entry", dut.entry[0], 32'h0000_00D0);

    // head=1, tags 1,2,3 live; mispredict tag 2
    ckpt.mispredict = 1'b1;
    ckpt.misTag     = 2'd2;
    tick();
    check("mis2_restore", 32'(ckpt.restore), 32'd1);
    check("mis2_status",  ckpt.statusRestore, 32'h22);
    check("mis2_tag",     32'(ckpt.snapTag), 32'd3);
    check("mis2_count",   32'(dut.count), 32'd2);
    tick();
    check("mis2_drop",    32'(ckpt.restore), 32'd0);
    check("mis2_hold",    ckpt.statusRestore, 32'h22);

    // unoccupied tag 0 ignored; capture still dropped by the mispredict
    ckpt.mispredict    = 1'b1;
    ckpt.misTag        = 2'd0;
    ckpt.snapValid     = 1'b1;
    ckpt.regStatusSnap = 32'h77;
    tick();
    check("misx_restore", 32'(ckpt.restore), 32'd0);
    check("misx_count",   32'(dut.count), 32'd2);
    check("misx_tag",     32'(ckpt.snapTag), 32'd3);

    // drain, then a retire at empty is ignored
    ckpt.branchCommit = 1'b1;
    tick();
    ckpt.branchCommit = 1'b1;
    tick();
    ckpt.branchCommit = 1'b1;
    tick();
    check("empty_count", 32'(dut.count), 32'd0);
    check("empty_head",  32'(dut.head), 32'd3);

    // head=3 wrap: tags 3 and 0, scrub bits 3 and 7, mispredict tag 0 + retire
    check("wrap_tag3", 32'(ckpt.snapTag), 32'd3);
    capture(32'h0000_0F0F);
    capture(32'hFFFF_FFFE);
    ckpt.commitValid = 1'b1;
    ckpt.regCommit   = 5'd3;
    tick();
    ckpt.commitValid = 1'b1;
    ckpt.regCommit   = 5'd7;
    tick();
    check("scrub_e3", dut.entry[3], 32'h0000_0F07);
    ckpt.mispredict   = 1'b1;
    ckpt.misTag       = 2'd0;
    ckpt.branchCommit = 1'b1;
    tick();
    check("wrap_restore", 32'(ckpt.restore), 32'd1);
    check("wrap_status",  ckpt.statusRestore, 32'hFFFF_FF76);
    check("wrap_head",    32'(dut.head), 32'd0);
    check("wrap_tag",     32'(ckpt.snapTag), 32'd1);
    check("wrap_count",   32'(dut.count), 32'd1);

    // misTag==head with retire and same-cycle scrub of bit 2
    ckpt.mispredict   = 1'b1;
    ckpt.misTag       = 2'd0;
    ckpt.branchCommit = 1'b1;
    ckpt.commitValid  = 1'b1;
    ckpt.regCommit    = 5'd2;
    tick();
    check("self_restore", 32'(ckpt.restore), 32'd1);
    check("self_status",  ckpt.statusRestore, 32'hFFFF_FF72);
    check("self_count",   32'(dut.count), 32'd0);
    check("self_head",    32'(dut.head), 32'd1);
    check("self_tag",     32'(ckpt.snapTag), 32'd1);

    // squashed slot is reused by the next capture
    capture(32'hAA);
    capture(32'hBB);
    ckpt.mispredict    = 1'b1;
    ckpt.misTag        = 2'd1;
    ckpt.snapValid     = 1'b1;
    ckpt.regStatusSnap = 32'hCC;
    tick();
    check("prio_status", ckpt.statusRestore, 32'hAA);
    check("prio_count",  32'(dut.count), 32'd1);
    check("prio_tag",    32'(ckpt.snapTag), 32'd2);
    capture(32'hDD);
    ckpt.mispredict = 1'b1;
    ckpt.misTag     = 2'd2;
    tick();
    check("reuse_restore", 32'(ckpt.restore), 32'd1);
    check("reuse_status",  ckpt.statusRestore, 32'hDD);
    check("reuse_tag",     32'(ckpt.snapTag), 32'd3);

    // asynchronous reset during the restore pulse
    reset = 1'b0;
    #1;
    check("arst_restore", 32'(ckpt.restore), 32'd0);
    check("arst_count",   32'(dut.count), 32'd0);
    check("arst_full",    32'(ckpt.full), 32'd0);
    check("arst_status",  ckpt.statusRestore, 32'h0);
    check("arst_tag",     32'(ckpt.snapTag), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
